output_vote_argmax: RTL and testbench
=====================================

Name: output_vote_argmax

Overview:
- Sits directly downstream of the 8-class XNOR-popcount output layer.
- Consumes one 8-bit binarized class vector per time step and accumulates per-class vote counts over N_STEP time steps.
- After the last step, scans the counters serially to find the winning class, then reports class index and score.
- Holds the result until cleared for the next sample.

Parameters:
- N_CLASS, 8: number of class bits per input beat.
- N_STEP, 32: time steps (valid beats) per sample.
- CNT_W, 6: vote counter width; must satisfy 2^CNT_W > N_STEP.
- IDX_W, 3: class index width, clog2(N_CLASS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart; zeroes counters and returns to ACC.
- data_in  in  N_CLASS  binarized class vector for the current step; bit i is a vote for class i.
- data_in_valid  in  1  data_in is valid this cycle.
- class_id  out  IDX_W  winning class index.
- class_score  out  CNT_W  vote count of the winning class.
- result_valid  out  1  single-cycle pulse when class_id/class_score update.
- done  out  1  high in DONE state.
- busy  out  1  high in SCAN state.
- drop_err  out  1  sticky; a valid beat arrived while not in ACC.

Behaviour:
- Reset values: all outputs 0; state ACC; all counters and step count 0; best registers 0.
- Reset is asynchronous, takes effect mid-operation in any state, and discards the partial sample.
- States:
  - ACC: accepting beats.
  - SCAN: argmax over the counters.
  - DONE: holding the result.
- ACC state:
  - Each beat with data_in_valid=1 increments cnt[i] by 1 for every i with data_in[i]=1.
  - The same beat increments step_cnt.
  - Cycles with data_in_valid=0 change nothing; gaps of any length are allowed.
- ACC to SCAN:
  - The transition happens on the beat with data_in_valid=1 and step_cnt==N_STEP-1.
  - That beat's votes are included.
  - step_cnt returns to 0.
- SCAN state:
  - One class is examined per cycle, index k = 0..N_CLASS-1.
  - k=0 loads best_score=cnt[0] and best_idx=0 unconditionally.
  - For k>0, best updates only if cnt[k] > best_score (strict), so ties resolve to the lowest index.
  - SCAN lasts exactly N_CLASS cycles.
- Result and DONE:
  - On the cycle after the last compare, class_id<=best_idx and class_score<=best_score.
  - result_valid pulses high for one cycle and the state becomes DONE.
  - Latency: if the final beat is sampled at edge T, result_valid is high in the cycle following edge T+N_CLASS+1 (9 cycles after the final beat for N_CLASS=8).
  - busy is high during SCAN only.
  - done is high from the result_valid cycle until clear or reset.
  - class_id and class_score hold their values until the next result.
- Dropped beats:
  - data_in_valid=1 while in SCAN or DONE: the beat is ignored, no counter changes, and drop_err is set.
  - drop_err clears only on reset or clear.
- clear:
  - Effective in any state.
  - Next state is ACC; cnt[], step_cnt, best, done, busy and drop_err go to 0.
  - class_id and class_score retain their last value.
  - No result_valid pulse is generated.
  - clear and data_in_valid in the same cycle: clear wins and the beat is discarded, not counted.
- Widths and overflow:
  - Counters saturate never; they cannot exceed N_STEP.
  - The comparison is unsigned over CNT_W bits.

Test Plan:
- All-zero input, 32 valid beats back-to-back -> result_valid 9 cycles after the last beat, class_id=0, class_score=0, done=1.
- data_in=8'b0010_0000 on all 32 beats, plus 8'b0000_0001 on 16 of them -> class_id=5, class_score=32.
- Tie: bits 2 and 6 set on all beats, other bits random at 50% -> class_id=2, class_score=32 (lowest index wins).
- 32 beats with random 0-5 cycle gaps, data_in=8'hFF on 20 beats and 8'h80 on 12 -> class_id=7, class_score=32; counts independent of gaps.
- Valid beat during SCAN, then clear in DONE -> drop_err=1 until clear; after clear, done=0, busy=0, and a new 32-beat sample produces a fresh result.
- rst_n asserted mid-SCAN (after 3 compare cycles), then a full new sample with class 4 only -> no stale result_valid; class_id=4, class_score=32.

Source files
------------

// File: rtl/output_vote_argmax.sv
// Vote accumulator and serial argmax behind the 8-class XNOR-popcount output layer.
// Counts per-class votes over N_STEP valid beats, scans the counters one class
// per cycle, then presents the winning class index and its score until cleared.

// Per-class vote counter; one instance per class bit.
module ova_lane #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  // Counter zeroes on clear and steps once per accepted vote; no saturation
  // logic is needed because it cannot exceed N_STEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (inc_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module output_vote_argmax #(
  parameter int N_CLASS = 8,
  parameter int N_STEP  = 32,
  parameter int CNT_W   = 6,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [N_CLASS-1:0] data_in,
  input  logic               data_in_valid,
  output logic [IDX_W-1:0]   class_id,
  output logic [CNT_W-1:0]   class_score,
  output logic               result_valid,
  output logic               done,
  output logic               busy,
  output logic               drop_err
);
  // RES is the one-cycle hand-off after the last compare where the result
  // registers load; it keeps SCAN exactly N_CLASS cycles long.
  typedef enum logic [1:0] {ACC, SCAN, RES, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                step_q, step_d;
  logic [IDX_W-1:0]                k_q, k_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic [CNT_W-1:0]                best_score_q, best_score_d;
  logic [IDX_W-1:0]                class_id_q, class_id_d;
  logic [CNT_W-1:0]                class_score_q, class_score_d;
  logic                            rv_q, rv_d;
  logic                            drop_q, drop_d;
  logic [N_CLASS-1:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]                cur_cnt;
  logic                            beat_acc;

  // A beat counts only in ACC and only when clear is not also asserted.
  assign beat_acc = data_in_valid && (state_q == ACC) && !clear;

  for (genvar i = 0; i < N_CLASS; i++) begin : g_lane
    ova_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .inc_i   (beat_acc && data_in[i]),
      .cnt_o   (cnt[i])
    );
  end

  assign cur_cnt = cnt[k_q];

  // Next-state: step counting, serial argmax, result load and sticky drop flag.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    k_d           = k_q;
    best_idx_d    = best_idx_q;
    best_score_d  = best_score_q;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    rv_d          = 1'b0;
    drop_d        = drop_q;
    if (clear) begin
      state_d      = ACC;
      step_d       = '0;
      k_d          = '0;
      best_idx_d   = '0;
      best_score_d = '0;
      drop_d       = 1'b0;
    end else begin
      if (data_in_valid && state_q != ACC) drop_d = 1'b1;
      case (state_q)
        ACC: begin
          if (data_in_valid) begin
            if (step_q == CNT_W'(N_STEP - 1)) begin
              step_d  = '0;
              k_d     = '0;
              state_d = SCAN;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
        SCAN: begin
          // Strict compare: ties keep the lower index.
          if (k_q == '0 || cur_cnt > best_score_q) begin
            best_score_d = cur_cnt;
            best_idx_d   = k_q;
          end
          if (k_q == IDX_W'(N_CLASS - 1)) begin
            k_d     = '0;
            state_d = RES;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        RES: begin
          class_id_d    = best_idx_q;
          class_score_d = best_score_q;
          rv_d          = 1'b1;
          state_d       = DONE;
        end
        DONE: ;
        default: state_d = ACC;
      endcase
    end
  end

  // State and datapath registers; reset discards any partial sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACC;
      step_q        <= '0;
      k_q           <= '0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      class_id_q    <= '0;
      class_score_q <= '0;
      rv_q          <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      k_q           <= k_d;
      best_idx_q    <= best_idx_d;
      best_score_q  <= best_score_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
      rv_q          <= rv_d;
      drop_q        <= drop_d;
    end
  end

  assign class_id     = class_id_q;
  assign class_score  = class_score_q;
  assign result_valid = rv_q;
  assign done         = (state_q == DONE);
  assign busy         = (state_q == SCAN);
  assign drop_err     = drop_q;
endmodule

// File: tb/tb_output_vote_argmax.sv
// Directed bench for output_vote_argmax: vote patterns, ties, gaps, drops,
// clear and mid-scan reset, with hand-computed expected class/score/latency.
module tb_output_vote_argmax;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic [2:0] class_id;
  logic [5:0] class_score;
  logic       result_valid, done, busy, drop_err;

  int nvec = 0;
  int nerr = 0;
  int rv_seen = 0;

  output_vote_argmax dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
    .data_in_valid(data_in_valid), .class_id(class_id), .class_score(class_score),
    .result_valid(result_valid), .done(done), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Running count of result pulses, sampled away from the active edge.
  always @(negedge clk) if (rst_n && result_valid) rv_seen++;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d);
    data_in = d; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0; data_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Waits for result_valid after the final beat; returns cycles elapsed.
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (result_valid) break;
    end
    if (!result_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_result(input string tag, input int id, input int score);
    int lat;
    chk({tag, "_busy"}, busy, 1);
    wait_result(tag, lat);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_id"}, class_id, id);
    chk({tag, "_score"}, class_score, score);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    idle(1);
    chk({tag, "_pulse1"}, result_valid, 0);
    chk({tag, "_hold_done"}, done, 1);
  endtask

  initial begin
    int snap, lat;
    logic [7:0] d;
    #12;
    chk("rst_id", class_id, 0);
    chk("rst_score", class_score, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero votes: class 0 wins with score 0.
    for (int i = 0; i < 32; i++) beat(8'h00);
    check_result("zero", 0, 0);
    do_clear();

    // Class 5 on every beat, class 0 on half.
    for (int i = 0; i < 32; i++) beat(i < 16 ? 8'h21 : 8'h20);
    check_result("c5", 5, 32);
    do_clear();

    // Tie between classes 2 and 6; lowest index wins.
    for (int i = 0; i < 32; i++) begin
      d = 8'($urandom) | 8'h44;
      beat(d);
    end
    check_result("tie", 2, 32);
    do_clear();

    // Random gaps between beats must not affect counts.
    for (int i = 0; i < 32; i++) begin
      idle($urandom_range(0, 5));
      beat(i < 20 ? 8'hFF : 8'h80);
    end
    check_result("gap", 7, 32);
    do_clear();

    // Beat during SCAN is dropped and flagged; clear restores idle.
    for (int i = 0; i < 32; i++) beat(8'h02);
    idle(2);
    beat(8'h02);
    chk("drop_set", drop_err, 1);
    chk("drop_busy", busy, 1);
    wait_result("drop", lat);
    chk("drop_id", class_id, 1);
    chk("drop_score", class_score, 32);
    chk("drop_sticky", drop_err, 1);
    beat(8'hFF);
    chk("drop_done", done, 1);
    do_clear();
    chk("clr_drop", drop_err, 0);
    chk("clr_done", done, 0);
    chk("clr_busy", busy, 0);
    chk("clr_keep_id", class_id, 1);
    chk("clr_keep_score", class_score, 32);

    // clear together with a valid beat: the beat must not count.
    clear = 1'b1; data_in = 8'h01; data_in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; data_in_valid = 1'b0;
    for (int i = 0; i < 32; i++) beat(8'h08);
    check_result("fresh", 3, 32);
    chk("fresh_drop", drop_err, 0);
    do_clear();

    // Reset in mid-SCAN discards the sample; next sample reports cleanly.
    for (int i = 0; i < 32; i++) beat(8'h01);
    idle(3);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", result_valid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    snap = rv_seen;
    for (int i = 0; i < 32; i++) beat(8'h10);
    chk("mid_no_stale", rv_seen - snap, 0);
    check_result("mid", 4, 32);
    chk("mid_pulses", rv_seen - snap, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
